serial_byte_assembler: RTL and testbench
========================================

Name: serial_byte_assembler

Overview:
- Upstream stage of the 8-bit output register. Deserializes a framed serial bit stream into parallel words.
- Presents each word on a valid/ready interface; byte_out drives the register's D input.
- When the consumer is a free-running register, byte_ready is tied high.

Parameters:
- WIDTH, 8, data bits per frame (min 2).
- MSB_FIRST, 1, 1 = first received bit lands in byte_out[WIDTH-1]; 0 = first bit lands in byte_out[0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ser_in  input  1  serial data bit, sampled only when ser_valid=1.
- ser_valid  input  1  ser_in carries a bit this cycle.
- frame_start  input  1  qualifies the current ser_valid bit as bit 0 of a new frame. Ignored when ser_valid=0.
- byte_out  output  WIDTH  assembled word, registered, stable while byte_valid=1.
- byte_valid  output  1  byte_out holds a complete word.
- byte_ready  input  1  consumer accepts the word. Transfer occurs on a cycle with byte_valid&&byte_ready.
- overrun  output  1  one-cycle pulse: a serial bit was dropped.
- parity_err  output  1  one-cycle pulse, PARITY_EN builds only; constant 0 otherwise.

Behaviour:
- Reset values: byte_out=0, byte_valid=0, overrun=0, parity_err=0. State=IDLE, bit count=0, shift register=0.
- Reset asserted mid-frame discards the partial word.
- States: IDLE, SHIFT, (PARITY), HOLD.
- IDLE:
  - ser_valid&&frame_start -> capture bit, cnt=1, go SHIFT.
  - ser_valid without frame_start -> bit ignored, no overrun.
- SHIFT:
  - Each ser_valid shifts in one bit, cnt+1.
  - ser_valid&&frame_start -> abort the current frame and restart: bit becomes bit 0, cnt=1, no overrun.
  - On the WIDTH-th bit: load byte_out from the shift path including that bit, assert byte_valid next cycle, go HOLD (or PARITY if enabled).
  - Latency: byte_valid rises exactly 1 cycle after the cycle sampling the last data bit.
- HOLD:
  - byte_valid=1 and byte_out frozen until transfer.
  - ser_valid without transfer -> bit dropped, overrun pulses the next cycle, state unchanged.
  - Transfer cycle: byte_valid drops next cycle, go IDLE.
  - Transfer in the same cycle as ser_valid&&frame_start -> new bit accepted as bit 0 (cnt=1, go SHIFT), no overrun.
  - Transfer in the same cycle as ser_valid without frame_start -> bit ignored, no overrun.
- byte_ready while byte_valid=0 has no effect.
- Bit counter width clog2(WIDTH+1). It never wraps: it resets to 0 or 1 on frame completion or restart.
- Gaps (ser_valid=0) are allowed anywhere in a frame; no timeout.

Optional Feature:
- Macro: SERIAL_BYTE_ASSEMBLER_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, state PARITY waits for one more ser_valid bit, the even-parity bit.
  - byte_out loads on that bit; byte_valid rises 1 cycle later.
  - If XOR(data bits, parity bit) != 0, parity_err pulses in the same cycle byte_valid first rises. The word is still delivered.
  - frame_start during PARITY restarts the frame as in SHIFT.
- Undefined: no PARITY state, parity_err tied 0, frame length = WIDTH bits.

Decomposition:
- Shared package/header: state encoding localparams (IDLE, SHIFT, PARITY, HOLD) and the default WIDTH constant, shared with the downstream register's bench.
- One sub-module is natural: sba_shift_unit. It holds the shift register, bit counter and running parity, with load/shift/clear controls. The FSM and handshake stay in the top.

Test Plan:
- MSB_FIRST=1, frame_start on the first bit, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> byte_out=8'hA5, byte_valid high 1 cycle after the 8th bit; with byte_ready=1 it drops the following cycle.
- MSB_FIRST=0, same bit sequence -> byte_out=8'hA5 reversed = 8'hA5 (palindrome). Repeat with 1,1,0,0,0,0,0,0 -> 8'h03.
- byte_ready=0 for 5 cycles in HOLD while 2 ser_valid bits arrive -> byte_out holds 8'hA5, overrun pulses twice. Then ready=1 -> transfer, IDLE.
- Send 3 bits, then frame_start with a new frame 8'h3C -> output 8'h3C only, no overrun, a single byte_valid assertion.
- Assert reset after 4 bits of 8'hFF -> outputs 0, state IDLE. The following full frame 8'h81 is delivered correctly.
- PARITY_EN: frame 8'hA5 with parity bit 0 -> parity_err=0. Parity bit 1 -> parity_err pulses with byte_valid, byte_out=8'hA5.

Source files
------------

// File: rtl/serial_byte_assembler_pkg.sv
// Shared definitions for the serial byte assembler: state encoding and default word width.
// The downstream register's bench reuses SBA_WIDTH.
package serial_byte_assembler_pkg;
    localparam int SBA_WIDTH = 8;

    localparam logic [1:0] SBA_ST_IDLE   = 2'd0;
    localparam logic [1:0] SBA_ST_SHIFT  = 2'd1;
    localparam logic [1:0] SBA_ST_PARITY = 2'd2;
    localparam logic [1:0] SBA_ST_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = SBA_ST_IDLE,
        SHIFT  = SBA_ST_SHIFT,
        PARITY = SBA_ST_PARITY,
        HOLD   = SBA_ST_HOLD
    } sba_state_e;
endpackage

// File: rtl/sba_shift_unit.sv
// Shift register, bit counter and running data parity for the serial byte assembler.
// Priority of controls: clear, then load (new frame), then shift.
module sba_shift_unit #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic             bit_in,
    output logic [WIDTH-1:0] sreg,
    output logic [WIDTH-1:0] word_nxt,
    output logic [CNT_W-1:0] cnt,
    output logic             par
);
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;

    always_comb begin
        // Value the register would take if bit_in were shifted in this cycle.
        word_nxt = MSB_FIRST ? {sreg_q[WIDTH-2:0], bit_in} : {bit_in, sreg_q[WIDTH-1:1]};
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        if (clear) begin
            sreg_d = '0;
            cnt_d  = '0;
            par_d  = 1'b0;
        end else if (load) begin
            sreg_d = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bit_in} : {bit_in, {(WIDTH-1){1'b0}}};
            cnt_d  = CNT_W'(1);
            par_d  = bit_in;
        end else if (shift) begin
            sreg_d = word_nxt;
            cnt_d  = cnt_q + CNT_W'(1);
            par_d  = par_q ^ bit_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            par_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            par_q  <= par_d;
        end
    end

    assign sreg = sreg_q;
    assign cnt  = cnt_q;
    assign par  = par_q;
endmodule

// File: rtl/serial_byte_assembler.sv
// Deserializes a framed serial bit stream into WIDTH-bit words on a valid/ready interface.
// Define SERIAL_BYTE_ASSEMBLER_PARITY_EN to add a trailing even-parity bit per frame.
module serial_byte_assembler
    import serial_byte_assembler_pkg::*;
#(
    parameter int WIDTH     = SBA_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             overrun,
    output logic             parity_err
);
    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    sba_state_e       state_q, state_d;
    logic [WIDTH-1:0] byte_out_q, byte_out_d;
    logic             byte_valid_q, byte_valid_d;
    logic             overrun_q, overrun_d;
    logic             su_clear, su_load, su_shift, start;
    logic [WIDTH-1:0] sreg, word_nxt;
    logic [CNT_W-1:0] cnt;
    logic             par;
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    sba_shift_unit #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .CNT_W(CNT_W)) u_shift (
        .clk(clk), .reset(reset), .clear(su_clear), .load(su_load), .shift(su_shift),
        .bit_in(ser_in), .sreg(sreg), .word_nxt(word_nxt), .cnt(cnt), .par(par)
    );

    always_comb begin
        state_d      = state_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        overrun_d    = 1'b0;
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
        parity_err_d = 1'b0;
`endif
        su_clear     = 1'b0;
        su_load      = 1'b0;
        su_shift     = 1'b0;
        start        = ser_valid && frame_start;
        case (state_q)
            IDLE: if (start) begin
                su_load = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: if (start) begin
                su_load = 1'b1;
            end else if (ser_valid) begin
                if (cnt == LAST) begin
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
                    su_shift = 1'b1;
                    state_d  = PARITY;
`else
                    byte_out_d   = word_nxt;
                    byte_valid_d = 1'b1;
                    su_clear     = 1'b1;
                    state_d      = HOLD;
`endif
                end else begin
                    su_shift = 1'b1;
                end
            end
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
            PARITY: if (start) begin
                su_load = 1'b1;
                state_d = SHIFT;
            end else if (ser_valid) begin
                // Data is complete in sreg; this bit is parity only.
                byte_out_d   = sreg;
                byte_valid_d = 1'b1;
                parity_err_d = par ^ ser_in;
                su_clear     = 1'b1;
                state_d      = HOLD;
            end
`endif
            HOLD: if (byte_ready) begin
                byte_valid_d = 1'b0;
                if (start) begin
                    su_load = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end else if (ser_valid) begin
                overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            overrun_q    <= overrun_d;
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Not every shift-unit output is consumed in every build.
    logic unused_su;
    assign unused_su = ^{sreg, word_nxt, par};

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign overrun    = overrun_q;
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_byte_assembler.sv
// Directed bench for serial_byte_assembler: MSB-first and LSB-first instances share one stimulus.
module tb_serial_byte_assembler;
    logic       clk = 1'b0;
    logic       reset, ser_in, ser_valid, frame_start, byte_ready;
    logic [7:0] byte_out_m, byte_out_l;
    logic       byte_valid_m, byte_valid_l, overrun_m, overrun_l, parity_err_m, parity_err_l;

    serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_start(frame_start), .byte_out(byte_out_m), .byte_valid(byte_valid_m),
        .byte_ready(byte_ready), .overrun(overrun_m), .parity_err(parity_err_m)
    );
    serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_start(frame_start), .byte_out(byte_out_l), .byte_valid(byte_valid_l),
        .byte_ready(byte_ready), .overrun(overrun_l), .parity_err(parity_err_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;
    int vld_rises = 0;
    logic vld_prev = 1'b0;

    always @(negedge clk) begin
        if (overrun_m) ovr_cnt <= ovr_cnt + 1;
        if (byte_valid_m && !vld_prev) vld_rises <= vld_rises + 1;
        vld_prev <= byte_valid_m;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        ser_in      = b;
        ser_valid   = 1'b1;
        frame_start = fs;
        step(1);
        ser_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // bits[7] goes on the wire first; frame_start marks it.
    task automatic send_frame(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            send_bit(bits[7-i], (i == 0));
            if (i == 6) chk("lat_pre_valid", 32'(byte_valid_m), 0);
        end
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
        chk("par_pre_valid", 32'(byte_valid_m), 0);
        send_bit(^bits, 1'b0);
`endif
    endtask

    typedef struct {
        logic [7:0] bits;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int o0, r0;
        vecs[0] = '{8'b10100101, 8'hA5, 8'hA5};
        vecs[1] = '{8'b11000000, 8'hC0, 8'h03};
        vecs[2] = '{8'b00111100, 8'h3C, 8'h3C};
        vecs[3] = '{8'b10000001, 8'h81, 8'h81};
        vecs[4] = '{8'b11100001, 8'hE1, 8'h87};

        reset = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; frame_start = 1'b0; byte_ready = 1'b1;
        step(2);
        chk("rst_byte_out", 32'(byte_out_m), 0);
        chk("rst_byte_valid", 32'(byte_valid_m), 0);
        chk("rst_overrun", 32'(overrun_m), 0);
        chk("rst_parity_err", 32'(parity_err_m), 0);
        reset = 1'b0;
        step(1);

        // Bits without frame_start in IDLE are ignored.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        step(1);
        chk("idle_ignore_valid", 32'(byte_valid_m), 0);
        chk("idle_ignore_ovr", 32'(ovr_cnt), 0);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].bits);
            chk("vec_valid_m", 32'(byte_valid_m), 1);
            chk("vec_out_m", 32'(byte_out_m), 32'(vecs[i].exp_m));
            chk("vec_valid_l", 32'(byte_valid_l), 1);
            chk("vec_out_l", 32'(byte_out_l), 32'(vecs[i].exp_l));
            chk("vec_overrun", 32'({overrun_m, overrun_l}), 0);
            chk("vec_parity_err", 32'({parity_err_m, parity_err_l}), 0);
            step(1);
            chk("vec_valid_drop", 32'(byte_valid_m), 0);
        end

        // Backpressure in HOLD with two dropped bits.
        byte_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'hA5);
        for (int c = 0; c < 5; c++) begin
            if (c == 1 || c == 3) send_bit(1'b1, 1'b0);
            else step(1);
            chk("hold_out", 32'(byte_out_m), 32'h A5);
            chk("hold_valid", 32'(byte_valid_m), 1);
            chk("hold_overrun", 32'(overrun_m), 32'(c == 1 || c == 3));
        end
        chk("hold_ovr_count", 32'(ovr_cnt - o0), 2);
        byte_ready = 1'b1;
        step(1);
        chk("hold_release", 32'(byte_valid_m), 0);

        // Restart mid-frame: only the second frame is delivered.
        step(1);
        r0 = vld_rises; o0 = ovr_cnt;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_frame(8'h3C);
        chk("restart_out", 32'(byte_out_m), 32'h3C);
        chk("restart_valid", 32'(byte_valid_m), 1);
        step(2);
        chk("restart_rises", 32'(vld_rises - r0), 1);
        chk("restart_ovr", 32'(ovr_cnt - o0), 0);

        // Transfer coinciding with a new frame_start bit.
        byte_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'hA5);
        chk("xfer_start_pre", 32'(byte_out_m), 32'hA5);
        byte_ready = 1'b1;
        send_frame(8'h3C);
        chk("xfer_start_out", 32'(byte_out_m), 32'h3C);
        chk("xfer_start_valid", 32'(byte_valid_m), 1);
        chk("xfer_start_ovr", 32'(ovr_cnt - o0), 0);
        step(2);

        // Reset mid-frame discards the partial word and returns to IDLE.
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_out", 32'(byte_out_m), 0);
        chk("mid_rst_valid", 32'(byte_valid_m), 0);
        step(1);
        reset = 1'b0;
        r0 = vld_rises;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        step(1);
        chk("mid_rst_idle", 32'(vld_rises - r0), 0);
        send_frame(8'h81);
        chk("post_rst_out", 32'(byte_out_m), 32'h81);
        chk("post_rst_valid", 32'(byte_valid_m), 1);
        step(2);

`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_EN
        // Wrong parity bit: word still delivered, error pulses with valid.
        for (int i = 0; i < 8; i++) send_bit(vecs[0].bits[7-i], (i == 0));
        send_bit(1'b1, 1'b0);
        chk("par_err_pulse", 32'(parity_err_m), 1);
        chk("par_err_valid", 32'(byte_valid_m), 1);
        chk("par_err_out", 32'(byte_out_m), 32'hA5);
        step(1);
        chk("par_err_clear", 32'(parity_err_m), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
